// File: rtl/counter_sweep_ctrl_if.sv
// counter_sweep_ctrl_if: signal bundle between a host/counter pair and the
// sweep sequencer.
//   master : host + counter side; drives start/abort/cfg_* and counter_out
//   slave  : sequencer side; drives load_en/up_down/counter_in and status
// Optional feature macro: SWEEP_IRQ_EN adds irq_clr (to slave) and irq (from slave).
interface counter_sweep_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 3,
    parameter int unsigned SWEEP_W   = 4
);
    logic                 start;
    logic                 abort;
    logic [CNT_WIDTH-1:0] cfg_lo;
    logic [CNT_WIDTH-1:0] cfg_hi;
    logic [SWEEP_W-1:0]   cfg_sweeps;
    logic [CNT_WIDTH-1:0] counter_out;
    logic                 load_en;
    logic                 up_down;
    logic [CNT_WIDTH-1:0] counter_in;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [SWEEP_W-1:0]   sweep_cnt;
`ifdef SWEEP_IRQ_EN
    logic                 irq_clr;
    logic                 irq;
`endif

    modport master (
        output start, abort, cfg_lo, cfg_hi, cfg_sweeps, counter_out,
`ifdef SWEEP_IRQ_EN
        output irq_clr,
        input  irq,
`endif
        input  load_en, up_down, counter_in, busy, done, err, sweep_cnt
    );

    modport slave (
        input  start, abort, cfg_lo, cfg_hi, cfg_sweeps, counter_out,
`ifdef SWEEP_IRQ_EN
        input  irq_clr,
        output irq,
`endif
        output load_en, up_down, counter_in, busy, done, err, sweep_cnt
    );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: sequencer for an up/down/load counter. On start it loads
// the low bound, runs the counter up to the high bound and back down for the
// programmed number of sweeps, then pulses done. While idle it holds load_en
// high so the counter stays parked at the last captured low bound.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      counter_sweep_ctrl_if.slave: start/abort/cfg_lo/cfg_hi/cfg_sweeps/
//            counter_out in; load_en/up_down/counter_in/busy/done/err/sweep_cnt out
// Optional feature macro: SWEEP_IRQ_EN adds a sticky irq (set by done or err,
// cleared by irq_clr, set wins over clear).
module counter_sweep_ctrl #(
    parameter int unsigned CNT_WIDTH = 3,
    parameter int unsigned SWEEP_W   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    counter_sweep_ctrl_if.slave bus
);
    localparam int unsigned SW1 = SWEEP_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_lo;
    logic [CNT_WIDTH-1:0] r_hi;
    logic [SWEEP_W-1:0]   r_sweeps;
    logic [CNT_WIDTH-1:0] r_counter_in;
    logic [SWEEP_W-1:0]   r_sweep_cnt;
    logic                 r_load_en;
    logic                 r_up_down;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_cfg_ok;
    logic                 w_at_peak;
    logic                 w_at_floor;
    logic [SW1-1:0]       w_sweep_inc;
    logic                 w_more;

    assign w_cfg_ok    = (bus.cfg_lo < bus.cfg_hi) && (bus.cfg_sweeps != '0);
    // Turn one step early: the counter moves on the same edge the direction flips.
    assign w_at_peak   = (bus.counter_out == CNT_WIDTH'(r_hi - CNT_WIDTH'(1)));
    assign w_at_floor  = (bus.counter_out == CNT_WIDTH'(r_lo + CNT_WIDTH'(1)));
    assign w_sweep_inc = SW1'(r_sweep_cnt) + SW1'(1);
    assign w_more      = (w_sweep_inc < SW1'(r_sweeps));

    // Sequencer state and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_lo         <= '0;
            r_hi         <= '0;
            r_sweeps     <= '0;
            r_counter_in <= '0;
            r_sweep_cnt  <= '0;
            r_load_en    <= 1'b1;
            r_up_down    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_load_en <= 1'b1;
                    if (bus.start && !bus.abort) begin
                        if (w_cfg_ok) begin
                            r_lo         <= bus.cfg_lo;
                            r_hi         <= bus.cfg_hi;
                            r_sweeps     <= bus.cfg_sweeps;
                            r_counter_in <= bus.cfg_lo;
                            r_up_down    <= 1'b1;
                            r_sweep_cnt  <= '0;
                            r_busy       <= 1'b1;
                            r_state      <= S_LOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LOAD, S_UP, S_DOWN: begin
                    if (bus.abort) begin
                        r_load_en    <= 1'b1;
                        r_counter_in <= r_lo;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (r_state == S_LOAD) begin
                        r_load_en <= 1'b0;
                        r_up_down <= 1'b1;
                        r_state   <= S_UP;
                    end else if (r_state == S_UP) begin
                        if (w_at_peak) begin
                            r_up_down <= 1'b0;
                            r_state   <= S_DOWN;
                        end
                    end else if (w_at_floor) begin
                        r_sweep_cnt <= w_sweep_inc[SWEEP_W-1:0];
                        if (w_more) begin
                            r_up_down <= 1'b1;
                            r_state   <= S_UP;
                        end else begin
                            r_load_en <= 1'b1;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.load_en    = r_load_en;
    assign bus.up_down    = r_up_down;
    assign bus.counter_in = r_counter_in;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.sweep_cnt  = r_sweep_cnt;

`ifdef SWEEP_IRQ_EN
    logic r_irq;
    logic w_irq_set;

    // Same conditions that raise done or err on this edge
    assign w_irq_set = ((r_state == S_IDLE) && bus.start && !bus.abort && !w_cfg_ok) ||
                       ((r_state == S_DOWN) && !bus.abort && w_at_floor && !w_more);

    // Sticky interrupt; set has priority over clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (bus.irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign bus.irq = r_irq;
`endif
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: directed vector table, hand-written corner
// sequences (abort, abort+start, reset mid-run, irq when SWEEP_IRQ_EN) and
// randomized runs checked against a trace model built from the sweep rules.
`timescale 1ns/1ps
module tb_counter_sweep_ctrl;
    localparam int unsigned CW = 3;
    localparam int unsigned SW = 4;

    typedef struct {
        logic [CW-1:0] lo;
        logic [CW-1:0] hi;
        logic [SW-1:0] sw;
        bit            exp_err;
        int            exp_done;
        int            exp_sc;
    } vec_t;

    logic          clk;
    logic          reset_n;
    logic [CW-1:0] r_cnt;
    int            n_checks;
    int            n_err;
    logic [CW-1:0] m_lo;
    logic [SW-1:0] m_sc;
    vec_t          vecs [6];

    counter_sweep_ctrl_if #(.CNT_WIDTH(CW), .SWEEP_W(SW)) bus ();

    counter_sweep_ctrl #(.CNT_WIDTH(CW), .SWEEP_W(SW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural up/down/load counter: load wins, else +/-1 with wrap
    always @(posedge clk) begin
        if (bus.load_en)      r_cnt <= bus.counter_in;
        else if (bus.up_down) r_cnt <= r_cnt + CW'(1);
        else                  r_cnt <= r_cnt - CW'(1);
    end
    assign bus.counter_out = r_cnt;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One full run; expected trace is lo, then lo+1..hi, hi-1..lo per sweep.
    task automatic run_sweep(input logic [CW-1:0] lo, input logic [CW-1:0] hi,
                             input logic [SW-1:0] sw, input int exp_done,
                             input int exp_sc, input bit noise);
        int   trace[$];
        int   n_done;
        int   done_at;
        int   toggles;
        int   exp_val;
        logic prev_ud;
        n_done  = 2 + 2 * (int'(hi) - int'(lo)) * int'(sw);
        done_at = -1;
        toggles = 0;
        prev_ud = 1'b1;
        trace.push_back(int'(lo));
        for (int s = 0; s < int'(sw); s++) begin
            for (int v = int'(lo) + 1; v <= int'(hi); v++) trace.push_back(v);
            for (int v = int'(hi) - 1; v >= int'(lo); v--) trace.push_back(v);
        end
        bus.cfg_lo     = lo;
        bus.cfg_hi     = hi;
        bus.cfg_sweeps = sw;
        bus.abort      = 1'b0;
        bus.start      = 1'b1;
        for (int n = 1; n <= n_done + 1; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                exp_val = (n - 2 < trace.size()) ? trace[n-2] : int'(lo);
                chk($sformatf("counter_out[n=%0d]", n), 32'(bus.counter_out), exp_val);
            end
            chk($sformatf("busy[n=%0d]", n), 32'(bus.busy), 32'(n < n_done));
            chk($sformatf("done[n=%0d]", n), 32'(bus.done), 32'(n == n_done));
            chk($sformatf("load_en[n=%0d]", n), 32'(bus.load_en), 32'((n == 1) || (n >= n_done)));
            chk($sformatf("err[n=%0d]", n), 32'(bus.err), 32'(0));
            chk($sformatf("counter_in[n=%0d]", n), 32'(bus.counter_in), 32'(lo));
            if (bus.done === 1'b1 && done_at < 0) done_at = n;
            if (n == 2) begin
                prev_ud = bus.up_down;
            end else if (n > 2 && n <= n_done) begin
                if (bus.up_down !== prev_ud) toggles++;
                prev_ud = bus.up_down;
            end
            if (n == n_done) chk("sweep_cnt_at_done", 32'(bus.sweep_cnt), 32'(exp_sc));
            if (noise && n <= n_done) begin
                bus.start      = 1'($urandom_range(0, 1));
                bus.cfg_lo     = CW'($urandom);
                bus.cfg_hi     = CW'($urandom);
                bus.cfg_sweeps = SW'($urandom);
            end else begin
                bus.start      = 1'b0;
                bus.cfg_lo     = lo;
                bus.cfg_hi     = hi;
                bus.cfg_sweeps = sw;
            end
        end
        chk("done_latency", 32'(done_at), 32'(exp_done));
        chk("up_down_toggles", 32'(toggles), 32'(2 * int'(sw) - 1));
        chk("sweep_cnt_after", 32'(bus.sweep_cnt), 32'(exp_sc));
        m_lo = lo;
        m_sc = sw;
    endtask

    // Invalid configuration: one-cycle err, nothing else moves
    task automatic check_reject(input logic [CW-1:0] lo, input logic [CW-1:0] hi,
                                input logic [SW-1:0] sw);
        bus.cfg_lo     = lo;
        bus.cfg_hi     = hi;
        bus.cfg_sweeps = sw;
        bus.abort      = 1'b0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("rej_err", 32'(bus.err), 32'(1));
        chk("rej_busy", 32'(bus.busy), 32'(0));
        chk("rej_load_en", 32'(bus.load_en), 32'(1));
        chk("rej_counter_in", 32'(bus.counter_in), 32'(m_lo));
        chk("rej_sweep_cnt", 32'(bus.sweep_cnt), 32'(m_sc));
        chk("rej_done", 32'(bus.done), 32'(0));
        @(negedge clk);
        chk("rej_err_pulse", 32'(bus.err), 32'(0));
        chk("rej_busy2", 32'(bus.busy), 32'(0));
        chk("rej_load_en2", 32'(bus.load_en), 32'(1));
    endtask

    initial begin
        logic [CW-1:0] lo;
        logic [CW-1:0] hi;
        logic [SW-1:0] sw;
        bit            found;
        n_checks = 0;
        n_err    = 0;
        vecs[0] = '{lo: 3'd1, hi: 3'd3, sw: 4'd1, exp_err: 1'b0, exp_done: 6,  exp_sc: 1};
        vecs[1] = '{lo: 3'd0, hi: 3'd7, sw: 4'd2, exp_err: 1'b0, exp_done: 30, exp_sc: 2};
        vecs[2] = '{lo: 3'd4, hi: 3'd5, sw: 4'd3, exp_err: 1'b0, exp_done: 8,  exp_sc: 3};
        vecs[3] = '{lo: 3'd5, hi: 3'd5, sw: 4'd1, exp_err: 1'b1, exp_done: 0,  exp_sc: 0};
        vecs[4] = '{lo: 3'd2, hi: 3'd6, sw: 4'd0, exp_err: 1'b1, exp_done: 0,  exp_sc: 0};
        vecs[5] = '{lo: 3'd6, hi: 3'd2, sw: 4'd3, exp_err: 1'b1, exp_done: 0,  exp_sc: 0};

        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.cfg_lo     = '0;
        bus.cfg_hi     = '0;
        bus.cfg_sweeps = '0;
`ifdef SWEEP_IRQ_EN
        bus.irq_clr    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_load_en", 32'(bus.load_en), 32'(1));
        chk("rst_counter_in", 32'(bus.counter_in), 32'(0));
        chk("rst_up_down", 32'(bus.up_down), 32'(1));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_err", 32'(bus.err), 32'(0));
        chk("rst_sweep_cnt", 32'(bus.sweep_cnt), 32'(0));
`ifdef SWEEP_IRQ_EN
        chk("rst_irq", 32'(bus.irq), 32'(0));
`endif
        reset_n = 1'b1;
        m_lo = '0;
        m_sc = '0;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].exp_err) check_reject(vecs[i].lo, vecs[i].hi, vecs[i].sw);
            else run_sweep(vecs[i].lo, vecs[i].hi, vecs[i].sw, vecs[i].exp_done, vecs[i].exp_sc, 1'b0);
        end

        // Abort in UP at counter_out==2, with a stray start mid-run
        bus.cfg_lo = 3'd1; bus.cfg_hi = 3'd6; bus.cfg_sweeps = 4'd2; bus.start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.start = (i == 1);
            if (i >= 1 && bus.counter_out == 3'd2 && bus.busy === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reached_2", 32'(found), 32'(1));
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'(0));
        chk("abort_load_en", 32'(bus.load_en), 32'(1));
        chk("abort_counter_in", 32'(bus.counter_in), 32'(1));
        chk("abort_done", 32'(bus.done), 32'(0));
        m_lo = 3'd1;
        m_sc = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done), 32'(0));
            chk("abort_idle", 32'(bus.busy), 32'(0));
            chk("abort_sweep_frozen", 32'(bus.sweep_cnt), 32'(0));
        end
        chk("abort_parked", 32'(bus.counter_out), 32'(1));

        // abort and start together in IDLE: abort wins
        bus.cfg_lo = 3'd2; bus.cfg_hi = 3'd5; bus.cfg_sweeps = 4'd1;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abst_busy", 32'(bus.busy), 32'(0));
        chk("abst_err", 32'(bus.err), 32'(0));
        chk("abst_counter_in", 32'(bus.counter_in), 32'(m_lo));
        @(negedge clk);
        chk("abst_busy2", 32'(bus.busy), 32'(0));

        // Reset during DOWN
        bus.cfg_lo = 3'd0; bus.cfg_hi = 3'd7; bus.cfg_sweeps = 4'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'(1));
        chk("pre_rst_down", 32'(bus.up_down), 32'(0));
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_load_en", 32'(bus.load_en), 32'(1));
        chk("mid_rst_counter_in", 32'(bus.counter_in), 32'(0));
        chk("mid_rst_up_down", 32'(bus.up_down), 32'(1));
        chk("mid_rst_busy", 32'(bus.busy), 32'(0));
        chk("mid_rst_done", 32'(bus.done), 32'(0));
        chk("mid_rst_err", 32'(bus.err), 32'(0));
        chk("mid_rst_sweep_cnt", 32'(bus.sweep_cnt), 32'(0));
`ifdef SWEEP_IRQ_EN
        chk("mid_rst_irq", 32'(bus.irq), 32'(0));
`endif
        reset_n = 1'b1;
        m_lo = '0;
        m_sc = '0;
        @(negedge clk);
        chk("post_rst_done", 32'(bus.done), 32'(0));
        chk("post_rst_busy", 32'(bus.busy), 32'(0));

        // Randomized runs with cfg/start noise during the run
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                lo = CW'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) begin
                    hi = CW'($urandom_range(0, int'(lo)));
                    sw = SW'($urandom_range(1, 15));
                end else begin
                    hi = 3'd7;
                    sw = '0;
                    if (lo == 3'd7) lo = 3'd0;
                end
                check_reject(lo, hi, sw);
            end else begin
                lo = CW'($urandom_range(0, 6));
                hi = CW'($urandom_range(int'(lo) + 1, 7));
                sw = SW'($urandom_range(1, 3));
                run_sweep(lo, hi, sw, 2 + 2 * (int'(hi) - int'(lo)) * int'(sw), int'(sw), 1'b1);
            end
        end

`ifdef SWEEP_IRQ_EN
        bus.irq_clr = 1'b1;
        @(negedge clk);
        bus.irq_clr = 1'b0;
        chk("irq_cleared", 32'(bus.irq), 32'(0));
        run_sweep(3'd1, 3'd3, 4'd1, 6, 1, 1'b0);
        chk("irq_set_by_done", 32'(bus.irq), 32'(1));
        bus.irq_clr = 1'b1;
        @(negedge clk);
        bus.irq_clr = 1'b0;
        chk("irq_clr", 32'(bus.irq), 32'(0));
        @(negedge clk);
        chk("irq_stays_clear", 32'(bus.irq), 32'(0));
        bus.cfg_lo = 3'd5; bus.cfg_hi = 3'd5; bus.cfg_sweeps = 4'd1;
        bus.start = 1'b1; bus.irq_clr = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.irq_clr = 1'b0;
        chk("irq_setclr_err", 32'(bus.err), 32'(1));
        chk("irq_set_wins", 32'(bus.irq), 32'(1));
        @(negedge clk);
        chk("irq_sticky", 32'(bus.irq), 32'(1));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer for counter_up_down_load_nbit: drives its load_en, up_down and counter_in, and watches counter_out. On start it loads a low bound, then runs the counter up to a high bound and back down, for a programmed number of sweeps. It reports busy, sweep progress and a done pulse. Between runs it parks the counter at the low bound by holding load active.

Parameters:
CNT_WIDTH, 3, width of the counter datapath (must match the counter instance)
SWEEP_W, 4, width of the sweep-count configuration and status

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  start request, sampled in IDLE only
abort  input  1  stop the current run, return to IDLE
cfg_lo  input  CNT_WIDTH  lower sweep bound
cfg_hi  input  CNT_WIDTH  upper sweep bound
cfg_sweeps  input  SWEEP_W  number of up/down sweeps, 1..2^SWEEP_W-1
counter_out  input  CNT_WIDTH  current value from the counter
load_en  output  1  load strobe to the counter
up_down  output  1  direction to the counter, 1=up, 0=down
counter_in  output  CNT_WIDTH  load value to the counter
busy  output  1  high in LOAD, UP and DOWN
done  output  1  one-cycle pulse when a run completes
err  output  1  one-cycle pulse when start is rejected
sweep_cnt  output  SWEEP_W  completed sweeps in the current or last run

Behaviour:
- Reset is synchronous and active-low on reset_n; clk is the only clock.
- Reset values: state=IDLE, load_en=1, counter_in=0, up_down=1, busy=0, done=0, err=0, sweep_cnt=0.
- All outputs are registered.
- Counter model: load has priority. Otherwise the counter moves by 1 per clock in the direction of up_down and wraps modulo 2^CNT_WIDTH.
- IDLE:
  - load_en=1; counter_in holds the last captured lo (parks the counter there).
  - start with abort=0 and cfg_lo<cfg_hi and cfg_sweeps!=0: capture lo, hi and sweeps; counter_in<=cfg_lo; load_en<=1; up_down<=1; sweep_cnt<=0; go to LOAD.
  - start with an invalid configuration: err=1 for one cycle; stay in IDLE; counter_in and sweep_cnt are unchanged.
- LOAD: lasts 1 cycle. Then load_en<=0, up_down<=1, go to UP; counter_out becomes lo.
- UP: when counter_out==hi-1, set up_down<=0 and go to DOWN. The next counter_out is hi; the peak is visible for exactly 1 cycle.
- DOWN: when counter_out==lo+1:
  - Always: sweep_cnt<=sweep_cnt+1.
  - If sweep_cnt+1 < sweeps: up_down<=1 and go to UP.
  - Otherwise: load_en<=1, done<=1, go to DONE.
- DONE: lasts 1 cycle, with counter_out==lo and done=1. Then done<=0 and go to IDLE.
- Expected counter_out trace: lo..hi..lo per sweep, with no repeated or skipped values.
- Latency: done is high exactly 2+2*(hi-lo)*sweeps cycles after the edge that sampled start.
- hi-lo==1 must work: trace is lo, hi, lo per sweep.
- abort in LOAD, UP or DOWN: next cycle state=IDLE, load_en=1, counter_in=lo, busy=0; no done; sweep_cnt is frozen.
- abort and start in the same IDLE cycle: abort wins and start is ignored.
- start while busy is ignored.
- cfg_* changes during a run have no effect; only the captured copies are used.
- reset_n=0 mid-run: reset values apply at the next edge, with no done and no err.

Optional Feature:
Macro SWEEP_IRQ_EN.
- Defined: adds input irq_clr (1 bit) and output irq (1 bit, reset 0).
  - irq is set on the cycle done or err asserts and stays set until irq_clr.
  - If set and clear happen in the same cycle, set wins.
- Undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Case 1: lo=1, hi=3, sweeps=1, pulse start -> counter_out 1,2,3,2,1; done high exactly 6 cycles after the start edge, for 1 cycle; sweep_cnt=1.
- Case 2: lo=0, hi=7, sweeps=2 -> two full 0..7..0 sweeps with no wrap; done at cycle 30; up_down toggles 3 times.
- Case 3: lo=4, hi=5, sweeps=3 -> trace 4,5,4,5,4,5,4; done at cycle 8; sweep_cnt=3.
- Case 4: lo=5, hi=5 (also lo=2, hi=6, sweeps=0) -> err 1-cycle pulse, busy stays 0, load_en stays 1.
- Case 5: abort in UP while counter_out=2 (lo=1, hi=6) -> next cycle busy=0, load_en=1, counter_in=1; no done. Start pulsed during the run -> ignored.
- Case 6: reset_n=0 during DOWN -> next cycle all outputs at reset values. With SWEEP_IRQ_EN: irq set by Case 1 done, cleared by irq_clr; set+clr in the same cycle leaves irq=1.
